// File: rtl/fb_sram_arbiter.sv
// fb_sram_arbiter: sole owner of the frame-buffer SRAM port.
// Arbitrates display reads (front buffer), pixel writes and the back-buffer
// clear engine (priority read > clear step > write), drives the SRAM strobes
// and owns the double-buffer select bit, which only flips on a frame start.
// Optional build macro: SRAM_POWERDOWN_EN enables idle-sleep via zz_o.
module fb_sram_arbiter #(
  parameter int          ADDR_W       = 19,
  parameter int          DATA_W       = 24,
  parameter int          FRAME_PIXELS = 307200,
  parameter logic [23:0] CLEAR_COLOR  = 24'h000000,
  parameter int          SLEEP_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_ack_o,
  input  logic              clr_req_i,
  output logic              clr_busy_o,
  input  logic              swap_req_i,
  input  logic              frame_start_i,
  output logic              swap_ack_o,
  output logic              buffer_select_o,
  output logic [ADDR_W:0]   sram_addr_o,
  output logic [DATA_W-1:0] sram_wdata_o,
  input  logic [DATA_W-1:0] sram_rdata_i,
  output logic              ce_n_o,
  output logic              oe_n_o,
  output logic              lb_n_o,
  output logic              ub_n_o,
  output logic              sem_n_o,
  output logic              r_w_o,
  output logic              zz_o
);

  typedef enum logic [2:0] {IDLE, READ, READ_CAP, WRITE, CLEAR} state_t;

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FRAME_PIXELS - 1);

  state_t              state_q;
  logic                bs_q;
  logic                swap_pending_q;
  logic                swap_ack_q;
  logic                clr_busy_q;
  logic [ADDR_W-1:0]   clr_cnt_q;
  logic                rd_valid_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                wr_ack_q;
  logic [ADDR_W:0]     addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                ce_n_q;
  logic                oe_n_q;
  logic                byte_n_q;
  logic                r_w_q;

  logic                wake_hold;
  logic                grant_rd_d;
  logic                grant_clr_d;
  logic                grant_wr_d;

`ifdef SRAM_POWERDOWN_EN
  localparam int IW = $clog2(SLEEP_CYCLES + 1);

  logic [IW-1:0] idle_cnt_q;
  logic          zz_q;
  logic          any_req;

  assign any_req   = rd_req_i | wr_req_i | clr_req_i | clr_busy_q;
  // A pending request while asleep costs one IDLE cycle to bring the SRAM back.
  assign wake_hold = zz_q & any_req;
  assign zz_o      = zz_q;

  // Count quiet IDLE cycles; enter sleep after SLEEP_CYCLES of them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt_q <= '0;
      zz_q       <= 1'b0;
    end else if (state_q != IDLE || any_req) begin
      idle_cnt_q <= '0;
      zz_q       <= 1'b0;
    end else if (idle_cnt_q != IW'(SLEEP_CYCLES)) begin
      idle_cnt_q <= idle_cnt_q + IW'(1);
      if (idle_cnt_q == IW'(SLEEP_CYCLES - 1)) begin
        zz_q <= 1'b1;
      end
    end
  end
`else
  logic unused_sleep;

  assign unused_sleep = |SLEEP_CYCLES;
  assign wake_hold    = 1'b0;
  assign zz_o         = 1'b0;
`endif

  // Grant decision in IDLE; requests seen on the cycle their own ack/valid
  // is out are the tail of the previous handshake and must not re-grant.
  always_comb begin
    grant_rd_d  = 1'b0;
    grant_clr_d = 1'b0;
    grant_wr_d  = 1'b0;
    if (state_q == IDLE && !wake_hold) begin
      if (rd_req_i && !rd_valid_q) begin
        grant_rd_d = 1'b1;
      end else if (clr_busy_q) begin
        grant_clr_d = 1'b1;
      end else if (wr_req_i && !wr_ack_q) begin
        grant_wr_d = 1'b1;
      end
    end
  end

  // Transaction FSM with registered SRAM strobes, acks and clear engine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      clr_busy_q <= 1'b0;
      clr_cnt_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      wr_ack_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      byte_n_q   <= 1'b1;
      r_w_q      <= 1'b1;
    end else begin
      rd_valid_q <= 1'b0;
      wr_ack_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_rd_d) begin
            // Front buffer is the one not selected for writing.
            addr_q   <= {~bs_q, rd_addr_i};
            ce_n_q   <= 1'b0;
            oe_n_q   <= 1'b0;
            byte_n_q <= 1'b0;
            r_w_q    <= 1'b1;
            state_q  <= READ;
          end else if (grant_clr_d) begin
            addr_q   <= {bs_q, clr_cnt_q};
            wdata_q  <= DATA_W'(CLEAR_COLOR);
            ce_n_q   <= 1'b0;
            oe_n_q   <= 1'b1;
            byte_n_q <= 1'b0;
            r_w_q    <= 1'b0;
            state_q  <= CLEAR;
          end else if (grant_wr_d) begin
            addr_q   <= {bs_q, wr_addr_i};
            wdata_q  <= wr_data_i;
            ce_n_q   <= 1'b0;
            oe_n_q   <= 1'b1;
            byte_n_q <= 1'b0;
            r_w_q    <= 1'b0;
            state_q  <= WRITE;
          end
        end
        READ: begin
          state_q <= READ_CAP;
        end
        READ_CAP: begin
          rd_data_q  <= sram_rdata_i;
          rd_valid_q <= 1'b1;
          ce_n_q     <= 1'b1;
          oe_n_q     <= 1'b1;
          byte_n_q   <= 1'b1;
          state_q    <= IDLE;
        end
        WRITE: begin
          wr_ack_q <= 1'b1;
          ce_n_q   <= 1'b1;
          byte_n_q <= 1'b1;
          r_w_q    <= 1'b1;
          state_q  <= IDLE;
        end
        CLEAR: begin
          ce_n_q   <= 1'b1;
          byte_n_q <= 1'b1;
          r_w_q    <= 1'b1;
          state_q  <= IDLE;
          if (clr_cnt_q == CLR_LAST) begin
            clr_busy_q <= 1'b0;
            clr_cnt_q  <= '0;
          end else begin
            clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
      // A new clear request always restarts the walk from pixel 0.
      if (clr_req_i) begin
        clr_busy_q <= 1'b1;
        clr_cnt_q  <= '0;
      end
    end
  end

  // Buffer swap: only at frame start, and never while the back buffer is clearing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bs_q           <= 1'b0;
      swap_pending_q <= 1'b0;
      swap_ack_q     <= 1'b0;
    end else begin
      swap_ack_q <= 1'b0;
      if (frame_start_i && (swap_pending_q || swap_req_i) && !clr_busy_q) begin
        bs_q           <= ~bs_q;
        swap_ack_q     <= 1'b1;
        swap_pending_q <= 1'b0;
      end else if (swap_req_i) begin
        swap_pending_q <= 1'b1;
      end
    end
  end

  assign rd_valid_o      = rd_valid_q;
  assign rd_data_o       = rd_data_q;
  assign wr_ack_o        = wr_ack_q;
  assign clr_busy_o      = clr_busy_q;
  assign swap_ack_o      = swap_ack_q;
  assign buffer_select_o = bs_q;
  assign sram_addr_o     = addr_q;
  assign sram_wdata_o    = wdata_q;
  assign ce_n_o          = ce_n_q;
  assign oe_n_o          = oe_n_q;
  assign lb_n_o          = byte_n_q;
  assign ub_n_o          = byte_n_q;
  assign sem_n_o         = 1'b1;
  assign r_w_o           = r_w_q;

endmodule
